// File: rtl/mux_operand_fifo.sv
// Operand FIFO ahead of the mux tree: buffers {sel,a,b,c} bundles between a
// valid/ready producer and the mux-tree consumer, with synchronous flush.
module mux_operand_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       in_sel,
   input  logic [WIDTH-1:0]           in_a,
   input  logic [WIDTH-1:0]           in_b,
   input  logic [WIDTH-1:0]           in_c,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       out_sel,
   output logic [WIDTH-1:0]           out_a,
   output logic [WIDTH-1:0]           out_b,
   output logic [WIDTH-1:0]           out_c,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam int BW = 3*WIDTH + 1;

   logic [BW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push;
   logic          pop;

   // Ready comes from the registered count only: a same-cycle pop never frees a full slot.
   assign in_ready  = (count < CW'(DEPTH));
   assign out_valid = (count != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   assign {out_sel, out_a, out_b, out_c} = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         // Storage is left as-is; only the bookkeeping is cleared.
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= {in_sel, in_a, in_b, in_c};
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_mux_operand_fifo.sv
// Self-checking bench for mux_operand_fifo: queue-based reference model,
// directed scenarios with literal expectations, and a randomized phase.
module tb_mux_operand_fifo;

   localparam int WIDTH = 4;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH+1);

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             flush = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic             in_sel = 1'b0;
   logic [WIDTH-1:0] in_a = '0;
   logic [WIDTH-1:0] in_b = '0;
   logic [WIDTH-1:0] in_c = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic             out_sel;
   logic [WIDTH-1:0] out_a;
   logic [WIDTH-1:0] out_b;
   logic [WIDTH-1:0] out_c;
   logic [CW-1:0]    count;

   int total = 0;
   int bad   = 0;

   mux_operand_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_sel(in_sel), .in_a(in_a), .in_b(in_b), .in_c(in_c),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sel(out_sel), .out_a(out_a), .out_b(out_b), .out_c(out_c),
      .count(count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a plain queue of bundles; fresh means nothing pushed since reset.
   logic [3*WIDTH:0] q[$];
   bit               fresh = 1'b1;
   bit               m_push;
   bit               m_pop;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         fresh = 1'b1;
      end else if (flush) begin
         q.delete();
      end else begin
         m_push = in_valid && (q.size() < DEPTH);
         m_pop  = out_ready && (q.size() != 0);
         if (m_pop) void'(q.pop_front());
         if (m_push) begin
            q.push_back({in_sel, in_a, in_b, in_c});
            fresh = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      check("model_out_valid", 32'(out_valid), 32'(q.size() != 0));
      check("model_in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
      check("model_count", 32'(count), 32'(q.size()));
      if (q.size() != 0)
         check("model_head", 32'({out_sel, out_a, out_b, out_c}), 32'(q[0]));
      else if (fresh)
         check("model_zero_out", 32'({out_sel, out_a, out_b, out_c}), 32'd0);
   end

   task automatic drive(input bit iv, input bit sel, input int a, input int b, input int c,
                        input bit ordy, input bit fl);
      in_valid  = iv;
      in_sel    = sel;
      in_a      = WIDTH'(a);
      in_b      = WIDTH'(b);
      in_c      = WIDTH'(c);
      out_ready = ordy;
      flush     = fl;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      flush     = 1'b0;
   endtask

   initial begin
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_outs_zero", 32'({out_sel, out_a, out_b, out_c}), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("idle_count", 32'(count), 32'd0);

      // Single bundle, held until consumed
      drive(1, 1, 3, 5, 9, 0, 0);
      check("t2_valid", 32'(out_valid), 32'd1);
      check("t2_sel", 32'(out_sel), 32'd1);
      check("t2_a", 32'(out_a), 32'd3);
      check("t2_c", 32'(out_c), 32'd9);
      check("t2_count", 32'(count), 32'd1);
      drive(0, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      check("t2_hold_a", 32'(out_a), 32'd3);
      drive(0, 0, 0, 0, 0, 1, 0);
      check("t2_popped", 32'(out_valid), 32'd0);

      // Fill to full, overflow attempt, ordered drain
      for (int i = 1; i <= 4; i++) drive(1, 0, i, 0, 0, 0, 0);
      check("t3_count_full", 32'(count), 32'd4);
      check("t3_not_ready", 32'(in_ready), 32'd0);
      drive(1, 0, 5, 0, 0, 0, 0);
      check("t3_ignored", 32'(count), 32'd4);
      for (int i = 1; i <= 4; i++) begin
         check("t3_drain_a", 32'(out_a), 32'(i));
         drive(0, 0, 0, 0, 0, 1, 0);
      end
      check("t3_empty", 32'(out_valid), 32'd0);

      // Full with push and pop requested together
      for (int i = 1; i <= 4; i++) drive(1, 0, i, 0, 0, 0, 0);
      drive(1, 0, 5, 0, 0, 1, 0);
      check("t4_pop_only", 32'(count), 32'd3);
      check("t4_head", 32'(out_a), 32'd2);
      drive(1, 0, 6, 0, 0, 1, 0);
      check("t4_push_pop", 32'(count), 32'd3);
      for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 1, 0);

      // Streaming through pointer wrap
      for (int i = 0; i < 10; i++) begin
         drive(1, i[0], i, 15 - i, i + 2, 1, 0);
         check("t5_count", 32'(count), 32'd1);
         check("t5_a", 32'(out_a), 32'(i));
      end
      drive(0, 0, 0, 0, 0, 1, 0);

      // Randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 15),
               $urandom_range(0, 15), $urandom_range(0, 15),
               ($urandom_range(0, 2) != 0), ($urandom_range(0, 31) == 0));
      end

      // Flush overriding push and pop
      drive(0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) drive(1, 1, 8 + i, 1, 2, 0, 0);
      check("t6_pre_count", 32'(count), 32'd3);
      drive(1, 0, 12, 0, 0, 1, 1);
      check("t6_flush_count", 32'(count), 32'd0);
      check("t6_flush_valid", 32'(out_valid), 32'd0);
      check("t6_flush_ready", 32'(in_ready), 32'd1);

      // Asynchronous reset mid-stream
      drive(1, 0, 4, 0, 0, 0, 0);
      drive(1, 0, 6, 0, 0, 0, 0);
      #2 rst_n = 1'b0;
      #1;
      check("t6_async_valid", 32'(out_valid), 32'd0);
      check("t6_async_count", 32'(count), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      drive(1, 1, 7, 2, 11, 0, 0);
      check("t6_after_rst_a", 32'(out_a), 32'd7);
      check("t6_after_rst_c", 32'(out_c), 32'd11);
      drive(0, 0, 0, 0, 0, 1, 0);

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
